// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the request, response and ALU-side signals of
// alu_arbiter. Signal names carry the arbiter's point of view (i_ = into
// the arbiter, o_ = out of the arbiter).
//   slave  : the arbiter side
//   master : the environment side (requesters, response sinks, the ALU)
//   i_req_valid/o_req_ready   : per-requester request handshake (bit n = requester n)
//   i_req_op*/i_req_a*/i_req_b*: per-requester op code and operands
//   o_resp_valid/i_resp_ready : per-requester response handshake
//   o_resp_data/o_resp_err    : shared result and watchdog-timeout flag
//   o_alu_*/i_alu_*           : registered ALU operation and its result
interface alu_arbiter_if;
    logic [1:0]  i_req_valid;
    logic [1:0]  o_req_ready;
    logic [3:0]  i_req_op0;
    logic [3:0]  i_req_op1;
    logic [31:0] i_req_a0;
    logic [31:0] i_req_b0;
    logic [31:0] i_req_a1;
    logic [31:0] i_req_b1;
    logic [1:0]  o_resp_valid;
    logic [1:0]  i_resp_ready;
    logic [31:0] o_resp_data;
    logic        o_resp_err;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        o_alu_valid;
    logic [31:0] i_alu_out;
    logic        i_alu_valid;

    modport slave (
        input  i_req_valid, i_req_op0, i_req_op1,
        input  i_req_a0, i_req_b0, i_req_a1, i_req_b1,
        input  i_resp_ready, i_alu_out, i_alu_valid,
        output o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
        output o_alu_op, o_alu_a, o_alu_b, o_alu_valid
    );

    modport master (
        output i_req_valid, i_req_op0, i_req_op1,
        output i_req_a0, i_req_b0, i_req_a1, i_req_b1,
        output i_resp_ready, i_alu_out, i_alu_valid,
        input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
        input  o_alu_op, o_alu_a, o_alu_b, o_alu_valid
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between the
// execute pipeline (requester 0) and the microcode/CSR sequencer
// (requester 1). One operation in flight at a time; the variable ALU
// latency is absorbed in WAIT, and a watchdog returns an error response
// (data 0) if the ALU never signals a result.
// Ports:
//   i_clk  : clock, all logic on posedge
//   i_rst  : synchronous active-high reset
//   io_bus : alu_arbiter_if.slave (request, response and ALU signals)
module alu_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [3:0]  IDLE_OP  = 4'b0100
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_arbiter_if.slave  io_bus
);

    localparam int unsigned CW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    logic           r_prio;         // requester favoured when both are valid
    logic           r_owner;        // requester owning the in-flight op
    logic [3:0]     r_alu_op;
    logic [31:0]    r_alu_a;
    logic [31:0]    r_alu_b;
    logic           r_alu_valid;
    logic [1:0]     r_resp_valid;
    logic [31:0]    r_resp_data;
    logic           r_resp_err;
    logic [CW-1:0]  r_cnt;

    logic [1:0]     w_grant;
    logic [CW-1:0]  w_cnt_inc;

    // Grant is combinational and only offered while idle.
    always_comb begin
        w_grant = '0;
        if (r_state == S_IDLE) begin
            case (io_bus.i_req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
                default: w_grant = '0;
            endcase
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_alu_op     <= IDLE_OP;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_valid  <= 1'b0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant != '0) begin
                        // Captured straight into the ALU output registers so
                        // they appear during the single ISSUE cycle.
                        r_owner     <= w_grant[1];
                        r_prio      <= ~w_grant[1];
                        r_alu_op    <= w_grant[1] ? io_bus.i_req_op1 : io_bus.i_req_op0;
                        r_alu_a     <= w_grant[1] ? io_bus.i_req_a1  : io_bus.i_req_a0;
                        r_alu_b     <= w_grant[1] ? io_bus.i_req_b1  : io_bus.i_req_b0;
                        r_alu_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_alu_op    <= IDLE_OP;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_alu_valid <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (io_bus.i_alu_valid) begin
                        r_resp_data  <= io_bus.i_alu_out;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_state      <= S_RESP;
                    end else if (w_cnt_inc == CW'(MAX_WAIT - 1)) begin
                        // Timeout lands MAX_WAIT cycles after ISSUE.
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    if (io_bus.i_resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                        r_resp_err   <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.o_req_ready  = w_grant;
    assign io_bus.o_resp_valid = r_resp_valid;
    assign io_bus.o_resp_data  = r_resp_data;
    assign io_bus.o_resp_err   = r_resp_err;
    assign io_bus.o_alu_op     = r_alu_op;
    assign io_bus.o_alu_a      = r_alu_a;
    assign io_bus.o_alu_b      = r_alu_b;
    assign io_bus.o_alu_valid  = r_alu_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A transaction-level
// model predicts grants (round-robin rule), response timing (3 cycles for
// single-cycle ops, 4 for ADD/SUB, MAX_WAIT+1 on timeout), owner and data.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int unsigned MAX_WAIT = 4;
    localparam logic [3:0]  IDLE_OP  = 4'b0100;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLTU = 4'h8;

    logic clk = 1'b0;
    logic rst;
    logic stall;

    alu_arbiter_if bus();

    alu_arbiter #(.MAX_WAIT(MAX_WAIT), .IDLE_OP(IDLE_OP)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ALU environment: registered, 1 cycle for most ops, 2 for ADD/SUB.
    // Not reset, so a stale result can arrive after an arbiter reset.
    logic        alu_raw_v = 1'b0;
    logic [31:0] alu_raw_out = '0;
    logic        alu_p_v = 1'b0;
    logic [31:0] alu_p_res = '0;
    always @(posedge clk) begin
        alu_raw_v <= 1'b0;
        if (alu_p_v) begin
            alu_raw_v   <= 1'b1;
            alu_raw_out <= alu_p_res;
            alu_p_v     <= 1'b0;
        end
        if (bus.o_alu_valid === 1'b1) begin
            if (bus.o_alu_op == OP_ADD || bus.o_alu_op == OP_SUB) begin
                alu_p_v   <= 1'b1;
                alu_p_res <= ref_alu(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b);
            end else begin
                alu_raw_v   <= 1'b1;
                alu_raw_out <= ref_alu(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b);
            end
        end
    end
    assign bus.i_alu_valid = alu_raw_v & ~stall;
    assign bus.i_alu_out   = alu_raw_out;

    // Transaction-level model state
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_age;
    int          m_lat;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_data;
    logic        m_err;
    logic [31:0] m_resp_data;
    logic        m_resp_err;
    bit          acc [2];
    int          grants [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_last = 1;
        acc[0] = 0;
        acc[1] = 0;
    endtask

    task automatic model_step();
        logic [1:0] v;
        logic [1:0] exp_rdy;
        acc[0] = 0;
        acc[1] = 0;
        v = bus.i_req_valid;
        if (!m_busy) begin
            if (v == 2'b11) exp_rdy = (m_last == 0) ? 2'b10 : 2'b01;
            else            exp_rdy = v;
            check("req_ready_idle", 32'(bus.o_req_ready), 32'(exp_rdy));
            check("resp_valid_idle", 32'(bus.o_resp_valid), 32'd0);
            check("alu_valid_idle", 32'(bus.o_alu_valid), 32'd0);
            check("alu_op_idle", 32'(bus.o_alu_op), 32'(IDLE_OP));
            if (exp_rdy != 2'b00) begin
                m_owner = exp_rdy[1] ? 1 : 0;
                m_last  = m_owner;
                acc[m_owner] = 1;
                grants.push_back(m_owner);
                m_op = m_owner ? bus.i_req_op1 : bus.i_req_op0;
                m_a  = m_owner ? bus.i_req_a1  : bus.i_req_a0;
                m_b  = m_owner ? bus.i_req_b1  : bus.i_req_b0;
                m_busy = 1;
                m_age  = 0;
                if (stall) begin
                    m_lat  = int'(MAX_WAIT) + 1;
                    m_data = '0;
                    m_err  = 1'b1;
                end else begin
                    m_lat  = (m_op == OP_ADD || m_op == OP_SUB) ? 4 : 3;
                    m_data = ref_alu(m_op, m_a, m_b);
                    m_err  = 1'b0;
                end
            end
        end else begin
            m_age++;
            check("req_ready_busy", 32'(bus.o_req_ready), 32'd0);
            if (m_age == 1) begin
                check("issue_alu_valid", 32'(bus.o_alu_valid), 32'd1);
                check("issue_alu_op", 32'(bus.o_alu_op), 32'(m_op));
                check("issue_alu_a", bus.o_alu_a, m_a);
                check("issue_alu_b", bus.o_alu_b, m_b);
            end else begin
                check("busy_alu_valid", 32'(bus.o_alu_valid), 32'd0);
                check("busy_alu_op", 32'(bus.o_alu_op), 32'(IDLE_OP));
            end
            if (m_age < m_lat) begin
                check("resp_valid_early", 32'(bus.o_resp_valid), 32'd0);
            end else begin
                check("resp_owner", 32'(bus.o_resp_valid), (m_owner == 1) ? 32'd2 : 32'd1);
                check("resp_data", bus.o_resp_data, m_data);
                check("resp_err", 32'(bus.o_resp_err), 32'(m_err));
                if (bus.i_resp_ready[m_owner]) begin
                    m_resp_data = bus.o_resp_data;
                    m_resp_err  = bus.o_resp_err;
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (m_busy && k < limit) begin
            cycle();
            k++;
        end
        check("drain_done", 32'(m_busy), 32'd0);
    endtask

    task automatic drive(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.i_req_op0 = op; bus.i_req_a0 = a; bus.i_req_b0 = b;
        end else begin
            bus.i_req_op1 = op; bus.i_req_a1 = a; bus.i_req_b1 = b;
        end
        bus.i_req_valid[n] = 1'b1;
    endtask

    task automatic drop(input int n);
        bus.i_req_valid[n] = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},  32'(bus.o_req_ready),  32'd0);
        check({tag, "_resp_valid"}, 32'(bus.o_resp_valid), 32'd0);
        check({tag, "_resp_err"},   32'(bus.o_resp_err),   32'd0);
        check({tag, "_resp_data"},  bus.o_resp_data,       32'd0);
        check({tag, "_alu_op"},     32'(bus.o_alu_op),     32'(IDLE_OP));
        check({tag, "_alu_a"},      bus.o_alu_a,           32'd0);
        check({tag, "_alu_b"},      bus.o_alu_b,           32'd0);
        check({tag, "_alu_valid"},  32'(bus.o_alu_valid),  32'd0);
    endtask

    function automatic logic [3:0] rand_op();
        return 4'($urandom_range(0, 8));
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        int g0;
        rst = 1'b1;
        stall = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_op0 = IDLE_OP; bus.i_req_a0 = '0; bus.i_req_b0 = '0;
        bus.i_req_op1 = IDLE_OP; bus.i_req_a1 = '0; bus.i_req_b1 = '0;
        bus.i_resp_ready = 2'b11;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single XOR from requester 0
        drive(0, OP_XOR, 32'hF0F0_0000, 32'h0FF0_0000);
        cycle();
        drop(0);
        drain(12);
        check("xor_data", m_resp_data, 32'hFF00_0000);
        check("xor_err", 32'(m_resp_err), 32'd0);

        // ADD / SUB from requester 1
        drive(1, OP_ADD, 32'd5, 32'd7);
        cycle();
        drop(1);
        drain(12);
        check("add_data", m_resp_data, 32'd12);
        drive(1, OP_SUB, 32'd3, 32'd5);
        cycle();
        drop(1);
        drain(12);
        check("sub_data", m_resp_data, 32'hFFFF_FFFE);

        // Contention after reset: strict alternation starting with 0
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        grants.delete();
        drive(0, $urandom_range(0, 1) ? OP_SLT : OP_SLTU, $urandom(), $urandom());
        drive(1, $urandom_range(0, 1) ? OP_SLT : OP_SLTU, $urandom(), $urandom());
        for (int k = 0; k < 60 && grants.size() < 8; k++) begin
            cycle();
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) drive(n, $urandom_range(0, 1) ? OP_SLT : OP_SLTU, $urandom(), $urandom());
            end
        end
        drop(0);
        drop(1);
        drain(12);
        check("contention_count", 32'(grants.size()), 32'd8);
        foreach (grants[i]) check("contention_order", 32'(grants[i]), 32'(i % 2));

        // Backpressure: owner 0 not ready for 6 RESP cycles, non-owner ready ignored
        bus.i_resp_ready = 2'b10;
        drive(0, OP_XOR, $urandom(), $urandom());
        cycle();
        drop(0);
        drive(1, OP_OR, $urandom(), $urandom());
        repeat (8) cycle();
        bus.i_resp_ready = 2'b11;
        cycle();
        check("bp_released", 32'(m_busy), 32'd0);
        g0 = grants.size();
        cycle();
        check("bp_grant_next", 32'(grants.size() - g0), 32'd1);
        check("bp_grant_owner", 32'(grants[$]), 32'd1);
        drop(1);
        drain(12);

        // Watchdog: ALU never answers
        stall = 1'b1;
        drive(0, OP_AND, $urandom(), $urandom());
        cycle();
        drop(0);
        drain(20);
        check("wdog_err", 32'(m_resp_err), 32'd1);
        check("wdog_data", m_resp_data, 32'd0);
        stall = 1'b0;
        drive(1, OP_SLL, $urandom(), $urandom());
        cycle();
        drop(1);
        drain(12);
        check("wdog_after_err", 32'(m_resp_err), 32'd0);

        // Reset in WAIT during an ADD
        drive(0, OP_ADD, $urandom(), $urandom());
        cycle();
        drop(0);
        cycle();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset("rst_wait");
        @(posedge clk);
        #1;
        repeat (3) cycle();
        drive(0, OP_OR, $urandom(), $urandom());
        drive(1, OP_AND, $urandom(), $urandom());
        g0 = grants.size();
        cycle();
        drop(0);
        drop(1);
        check("rst_grant_count", 32'(grants.size() - g0), 32'd1);
        check("rst_grant_owner", 32'(grants[$]), 32'd0);
        drain(12);

        // Random traffic with random backpressure and request drops
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (acc[n] || !bus.i_req_valid[n]) begin
                    if ($urandom_range(0, 2) != 0) drive(n, rand_op(), $urandom(), $urandom());
                    else drop(n);
                end else if ($urandom_range(0, 7) == 0) begin
                    drop(n);
                end
            end
            bus.i_resp_ready = 2'($urandom_range(0, 3));
            cycle();
        end
        drop(0);
        drop(1);
        bus.i_resp_ready = 2'b11;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
